// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream channel bundle used by the packet arbiter: master (m) and slave (s) views.
interface axis_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic                  TVALID;
   logic                  TREADY;
   logic [DATA_WIDTH-1:0] TDATA;
   logic [ID_WIDTH-1:0]   TID;
   logic                  TLAST;

   modport m (output TVALID, output TDATA, output TID, output TLAST, input TREADY);
   modport s (input TVALID, input TDATA, input TID, input TLAST, output TREADY);
endinterface

// File: rtl/axis_packet_arbiter.sv
// Wormhole round-robin merge of CHANNEL_NUMBER AXI-Stream inputs into one registered output.
// Optional per-channel packet and stall counters when AXIS_ARB_STATS_EN is defined.
module axis_packet_arbiter #(
   parameter int                  DATA_WIDTH           = 32,
   parameter int                  ID_WIDTH             = 4,
   parameter int                  CHANNEL_NUMBER       = 5,
   parameter int                  CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
   parameter logic [ID_WIDTH-1:0] ROUTING_HEADER       = 4'hF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   axis_if.s                               in [0:CHANNEL_NUMBER-1],
   axis_if.m                               out,
   output logic [CHANNEL_NUMBER_WIDTH-1:0] current_grant,
   output logic                            locked
`ifdef AXIS_ARB_STATS_EN
   ,
   output logic [15:0]                     pkt_count [CHANNEL_NUMBER],
   output logic [15:0]                     stall_cycles
`endif
);

   typedef enum logic {IDLE, LOCKED} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ID_WIDTH-1:0]   id;
      logic                  last;
   } beat_t;

   state_t                          state;
   logic [CHANNEL_NUMBER_WIDTH-1:0] rr_ptr;
   logic [CHANNEL_NUMBER_WIDTH-1:0] pick;
   logic [CHANNEL_NUMBER_WIDTH-1:0] cand;
   logic                            pick_valid;
   int unsigned                     rr_idx;

   logic [CHANNEL_NUMBER-1:0] in_valid;
   logic [CHANNEL_NUMBER-1:0] in_last;
   logic [CHANNEL_NUMBER-1:0] req;
   logic [DATA_WIDTH-1:0]     in_data [CHANNEL_NUMBER];
   logic [ID_WIDTH-1:0]       in_id   [CHANNEL_NUMBER];

   logic  skid_ready;
   logic  accept;
   logic  pop;
   logic  wr_head;
   logic  [1:0] count;
   logic  [1:0] count_nxt;
   beat_t skid_head;
   beat_t skid_tail;
   beat_t in_beat;

   for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_chan
      assign in_valid[g] = in[g].TVALID;
      assign in_last[g]  = in[g].TLAST;
      assign in_data[g]  = in[g].TDATA;
      assign in_id[g]    = in[g].TID;
      assign req[g]      = in[g].TVALID && (in[g].TID == ROUTING_HEADER);
      assign in[g].TREADY = (state == LOCKED) &&
                            (current_grant == CHANNEL_NUMBER_WIDTH'(g)) && skid_ready;
   end

   // First requester strictly after the pointer, wrapping; the last served channel ranks lowest.
   always_comb begin
      pick       = rr_ptr;
      pick_valid = 1'b0;
      rr_idx     = 0;
      cand       = '0;
      for (int unsigned off = 1; off <= CHANNEL_NUMBER; off++) begin
         rr_idx = (32'(rr_ptr) + off) % 32'(CHANNEL_NUMBER);
         cand   = CHANNEL_NUMBER_WIDTH'(rr_idx);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick       = cand;
         end
      end
   end

   assign accept    = (state == LOCKED) && in_valid[current_grant] && skid_ready;
   assign pop       = (count != 2'd0) && out.TREADY;
   assign count_nxt = count + {1'b0, accept} - {1'b0, pop};
   assign wr_head   = ((count - {1'b0, pop}) == 2'd0);
   assign in_beat   = {in_data[current_grant], in_id[current_grant], in_last[current_grant]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         current_grant <= '0;
         locked        <= 1'b0;
         rr_ptr        <= CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  current_grant <= pick;
                  locked        <= 1'b1;
                  state         <= LOCKED;
               end
            end
            LOCKED: begin
               if (accept && in_last[current_grant]) begin
                  rr_ptr <= current_grant;
                  locked <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Head entry drives the output directly; a pop shifts the tail forward before any new write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= 2'd0;
         skid_ready <= 1'b1;
         skid_head  <= '0;
         skid_tail  <= '0;
      end else begin
         count      <= count_nxt;
         skid_ready <= (count_nxt != 2'd2);
         if (pop)
            skid_head <= skid_tail;
         if (accept) begin
            if (wr_head)
               skid_head <= in_beat;
            else
               skid_tail <= in_beat;
         end
      end
   end

   assign out.TVALID = (count != 2'd0);
   assign out.TDATA  = skid_head.data;
   assign out.TID    = skid_head.id;
   assign out.TLAST  = skid_head.last;

`ifdef AXIS_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < CHANNEL_NUMBER; c++)
            pkt_count[c] <= '0;
         stall_cycles <= '0;
      end else begin
         for (int unsigned c = 0; c < CHANNEL_NUMBER; c++) begin
            if (accept && in_last[current_grant] &&
                (current_grant == CHANNEL_NUMBER_WIDTH'(c)) && (pkt_count[c] != '1))
               pkt_count[c] <= pkt_count[c] + 16'd1;
         end
         if ((state == LOCKED) && in_valid[current_grant] && !skid_ready &&
             (stall_cycles != '1))
            stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: directed sequences, a grant-order table and
// randomized traffic against a packet-level round-robin model.
module tb_axis_packet_arbiter;

   localparam int          NCH = 5;
   localparam logic [3:0]  HDR = 4'hF;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  tid;
      logic        last;
   } flit_t;

   typedef struct {
      logic [4:0]      mask;
      int unsigned     n;
      logic [4:0][2:0] ord;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NCH-1:0] tv, tl, tr;
   logic [31:0]    td  [NCH];
   logic [3:0]     tid [NCH];
   logic           out_ready;
   logic           out_tvalid, out_tlast;
   logic [31:0]    out_tdata;
   logic [3:0]     out_tid;
   logic [2:0]     grant;
   logic           locked;
`ifdef AXIS_ARB_STATS_EN
   logic [15:0]    pkt_count [NCH];
   logic [15:0]    stall_cycles;
`endif

   axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) in_if [0:NCH-1] ();
   axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) out_if ();

   for (genvar g = 0; g < NCH; g++) begin : g_drv
      assign in_if[g].TVALID = tv[g];
      assign in_if[g].TDATA  = td[g];
      assign in_if[g].TID    = tid[g];
      assign in_if[g].TLAST  = tl[g];
      assign tr[g]           = in_if[g].TREADY;
   end
   assign out_if.TREADY = out_ready;
   assign out_tvalid    = out_if.TVALID;
   assign out_tdata     = out_if.TDATA;
   assign out_tid       = out_if.TID;
   assign out_tlast     = out_if.TLAST;

   axis_packet_arbiter #(
      .DATA_WIDTH(32), .ID_WIDTH(4), .CHANNEL_NUMBER(NCH), .ROUTING_HEADER(4'hF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in(in_if), .out(out_if),
      .current_grant(grant), .locked(locked)
`ifdef AXIS_ARB_STATS_EN
      , .pkt_count(pkt_count), .stall_cycles(stall_cycles)
`endif
   );

   flit_t       tx_q [NCH][$];
   flit_t       mq   [NCH][$];
   flit_t       rx_q [$];
   flit_t       exp_q [$];
   int unsigned rx_cyc [$];
   int unsigned n_cmp = 0, n_err = 0, cyc = 0;
   logic        gaps_en = 1'b0, bp_en = 1'b0, out_ready_fix = 1'b1;
   logic        prev_stall = 1'b0;
   flit_t       prev_beat;
   logic [NCH-1:0] acc;
   vec_t        vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic flit_t mkf(input logic [31:0] d, input logic [3:0] t, input logic l);
      flit_t f;
      f.data = d; f.tid = t; f.last = l;
      return f;
   endfunction

   function automatic vec_t mkv(input logic [4:0] m, input int unsigned n, input logic [2:0] o0,
                                input logic [2:0] o1, input logic [2:0] o2, input logic [2:0] o3,
                                input logic [2:0] o4);
      vec_t v;
      v.mask = m; v.n = n;
      v.ord[0] = o0; v.ord[1] = o1; v.ord[2] = o2; v.ord[3] = o3; v.ord[4] = o4;
      return v;
   endfunction

   function automatic logic all_empty();
      for (int c = 0; c < NCH; c++)
         if (tx_q[c].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic present();
      flit_t f;
      for (int c = 0; c < NCH; c++) begin
         if (tx_q[c].size() > 0) begin
            f      = tx_q[c][0];
            tv[c]  = (f.tid == HDR) || !gaps_en || ($urandom_range(0, 9) < 7);
            td[c]  = f.data;
            tid[c] = f.tid;
            tl[c]  = f.last;
         end else begin
            tv[c] = 1'b0; td[c] = '0; tid[c] = '0; tl[c] = 1'b0;
         end
      end
      out_ready = bp_en ? ($urandom_range(0, 3) != 0) : out_ready_fix;
   endtask

   // Sample handshakes mid-cycle, then advance the senders just after the edge.
   task automatic step();
      flit_t beat;
      @(negedge clk);
      beat = {out_tdata, out_tid, out_tlast};
      if (prev_stall) begin
         check("hold_valid", 64'(out_tvalid), 64'd1);
         check("hold_beat", 64'(beat), 64'(prev_beat));
      end
      acc = tv & tr;
      if (out_tvalid && out_ready) begin
         rx_q.push_back(beat);
         rx_cyc.push_back(cyc);
      end
      prev_stall = out_tvalid && !out_ready;
      prev_beat  = beat;
      cyc++;
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++)
         if (acc[c] && tx_q[c].size() > 0) void'(tx_q[c].pop_front());
      present();
   endtask

   task automatic wait_drain(input int unsigned budget);
      int unsigned k = 0;
      while (k < budget && !(all_empty() && !out_tvalid && !locked)) begin
         step();
         k++;
      end
      check("drain_done", 64'(all_empty() && !out_tvalid && !locked), 64'd1);
   endtask

   task automatic compare_rx(input string name);
      check({name, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
         check({name, "_beat"}, 64'(rx_q[k]), 64'(exp_q[k]));
   endtask

   task automatic clear_rx();
      rx_q.delete(); rx_cyc.delete(); exp_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int c = 0; c < NCH; c++) tx_q[c].delete();
      present();
      prev_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clear_rx();
   endtask

   initial begin
      int unsigned k, ptr, ch, npk [NCH];
      flit_t f, beat;

      vecs[0] = mkv(5'b10000, 1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0);
      vecs[1] = mkv(5'b01011, 3, 3'd0, 3'd1, 3'd3, 3'd0, 3'd0);
      vecs[2] = mkv(5'b00100, 1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
      vecs[3] = mkv(5'b11111, 5, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2);
      vecs[4] = mkv(5'b10001, 2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0);
      vecs[5] = mkv(5'b00011, 2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0);
      vecs[6] = mkv(5'b00001, 1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      vecs[7] = mkv(5'b10110, 3, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0);

      rst_n = 1'b0;
      present();
      repeat (2) @(negedge clk);
      check("rst_tvalid", 64'(out_tvalid), 64'd0);
      check("rst_tdata", 64'({out_tdata, out_tid, out_tlast}), 64'd0);
      check("rst_tready", 64'(tr), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_locked", 64'(locked), 64'd0);
`ifdef AXIS_ARB_STATS_EN
      check("rst_stall", 64'(stall_cycles), 64'd0);
      for (int c = 0; c < NCH; c++) check("rst_pkt_count", 64'(pkt_count[c]), 64'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 4-flit packet on ch2: grant, two-cycle latency, lock until TLAST, intact order.
      clear_rx();
      for (int i = 0; i < 4; i++) begin
         f = mkf(32'h2000_0000 + 32'(i), (i == 0) ? HDR : 4'h0, i == 3);
         tx_q[2].push_back(f);
         exp_q.push_back(f);
      end
      present();
      check("a_tready_idle", 64'(tr), 64'd0);
      step();
      check("a_grant", 64'(grant), 64'd2);
      check("a_locked", 64'(locked), 64'd1);
      check("a_latency1", 64'(out_tvalid), 64'd0);
      step();
      check("a_latency2", 64'(out_tvalid), 64'd1);
      k = 0;
      while (tx_q[2].size() > 0 && k < 20) begin
         check("a_lock_held", 64'(locked), 64'd1);
         step();
         k++;
      end
      check("a_unlock", 64'(locked), 64'd0);
      wait_drain(20);
      compare_rx("a");

      // Grant-order table with single-flit packets: order and one bubble between packets.
      for (int v = 0; v < 8; v++) begin
         clear_rx();
         for (int c = 0; c < NCH; c++)
            if (vecs[v].mask[c]) tx_q[c].push_back(mkf(32'hA000_0000 | (32'(v) << 8) | 32'(c), HDR, 1'b1));
         present();
         k = 0;
         while (rx_q.size() < vecs[v].n && k < 40) begin
            step();
            k++;
         end
         check("tbl_count", 64'(rx_q.size()), 64'(vecs[v].n));
         for (int i = 0; i < rx_q.size() && i < vecs[v].n; i++) begin
            beat = rx_q[i];
            check("tbl_order", 64'(beat.data[2:0]), 64'(vecs[v].ord[i]));
            if (i > 0) check("tbl_bubble", 64'(rx_cyc[i] - rx_cyc[i-1]), 64'd2);
         end
         wait_drain(20);
         check("tbl_last_grant", 64'(grant), 64'(vecs[v].ord[vecs[v].n - 1]));
      end

      // Non-header flit on an unlocked channel is never accepted.
      clear_rx();
      tx_q[1].push_back(mkf(32'h1111_0000, 4'h0, 1'b0));
      present();
      for (int i = 0; i < 10; i++) begin
         step();
         check("c_tready", 64'(tr[1]), 64'd0);
         check("c_out_idle", 64'(out_tvalid), 64'd0);
      end
      check("c_locked", 64'(locked), 64'd0);
      tx_q[1].delete();
      present();

      // Backpressure on ch4: two beats buffered, input stalls, then full delivery.
      clear_rx();
      out_ready_fix = 1'b0;
      for (int i = 0; i < 6; i++) begin
         f = mkf(32'h4000_0000 + 32'(i), (i == 0) ? HDR : 4'h0, i == 5);
         tx_q[4].push_back(f);
         exp_q.push_back(f);
      end
      present();
      repeat (5) step();
      check("d_buffered", 64'(tx_q[4].size()), 64'd4);
      check("d_tready", 64'(tr[4]), 64'd0);
      check("d_tvalid", 64'(out_tvalid), 64'd1);
      check("d_tdata", 64'(out_tdata), 64'h4000_0000);
      check("d_grant", 64'(grant), 64'd4);
      out_ready_fix = 1'b1;
      out_ready = 1'b1;
      wait_drain(40);
      compare_rx("d");

      // Single-flit ch3 packet followed immediately by a ch0 request.
      clear_rx();
      f = mkf(32'h3000_0000, HDR, 1'b1);
      tx_q[3].push_back(f); exp_q.push_back(f);
      present();
      k = 0;
      while (tx_q[3].size() > 0 && k < 10) begin
         step();
         k++;
      end
      f = mkf(32'h0000_00E0, HDR, 1'b1);
      tx_q[0].push_back(f); exp_q.push_back(f);
      present();
      step();
      check("e_grant", 64'(grant), 64'd0);
      check("e_locked", 64'(locked), 64'd1);
      wait_drain(20);
      compare_rx("e");
      if (rx_cyc.size() == 2) check("e_bubble", 64'(rx_cyc[1] - rx_cyc[0]), 64'd2);

      // Asynchronous reset mid-packet, then a fresh packet passes intact.
      clear_rx();
      for (int i = 0; i < 8; i++)
         tx_q[2].push_back(mkf(32'h2200_0000 + 32'(i), (i == 0) ? HDR : 4'h0, i == 7));
      present();
      repeat (4) step();
      check("f_locked_pre", 64'(locked), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("f_tvalid", 64'(out_tvalid), 64'd0);
      check("f_locked", 64'(locked), 64'd0);
      check("f_grant", 64'(grant), 64'd0);
      check("f_tready", 64'(tr), 64'd0);
      for (int c = 0; c < NCH; c++) tx_q[c].delete();
      present();
      prev_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_rx();
      for (int i = 0; i < 3; i++) begin
         f = mkf(32'h2300_0000 + 32'(i), (i == 0) ? HDR : 4'h0, i == 2);
         tx_q[2].push_back(f); exp_q.push_back(f);
      end
      present();
      wait_drain(30);
      compare_rx("f");
`ifdef AXIS_ARB_STATS_EN
      check("f_pkt_count", 64'(pkt_count[2]), 64'd1);
`endif

      // Random traffic: packets never interleave, order follows packet-level round robin.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            npk[c] = $urandom_range(0, 4);
            for (int p = 0; p < npk[c]; p++) begin
               k = $urandom_range(1, 5);
               for (int i = 0; i < k; i++) begin
                  f = mkf($urandom, (i == 0) ? HDR : 4'($urandom_range(0, 14)), i == k - 1);
                  tx_q[c].push_back(f);
                  mq[c].push_back(f);
               end
            end
         end
         ptr = NCH - 1;
         for (int guard = 0; guard < 100; guard++) begin
            ch = NCH;
            for (int off = 1; off <= NCH && ch == NCH; off++)
               if (mq[(ptr + off) % NCH].size() > 0) ch = (ptr + off) % NCH;
            if (ch == NCH) break;
            do begin
               f = mq[ch].pop_front();
               exp_q.push_back(f);
            end while (!f.last);
            ptr = ch;
         end
         gaps_en = 1'b1;
         bp_en   = 1'b1;
         present();
         wait_drain(4000);
         gaps_en = 1'b0;
         bp_en   = 1'b0;
         present();
         compare_rx("rand");
`ifdef AXIS_ARB_STATS_EN
         for (int c = 0; c < NCH; c++) check("rand_pkt_count", 64'(pkt_count[c]), 64'(npk[c]));
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
